// File: rtl/fifo_protocol_monitor.sv
// Protocol monitor for N_CH single-clock FIFO channels: shadow occupancy,
// sticky violation flags with first-error capture, and saturating full/empty coverage counters.
module fifo_protocol_monitor #(
  parameter int         N_CH     = 4,
  parameter int         DEPTH    = 16,
  parameter int         RD_LAT   = 1,
  parameter int         CNT_W    = 16,
  parameter logic [4:0] ERR_MASK = 5'b11111,
  localparam int        OCC_W    = $clog2(DEPTH + 1),
  localparam int        CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       wr_en,
  input  logic [N_CH-1:0]       wr_full,
  input  logic [N_CH-1:0]       rd_en,
  input  logic [N_CH-1:0]       rd_empty,
  input  logic [N_CH-1:0]       rd_valid,
  input  logic                  err_clr,
  output logic [5*N_CH-1:0]     err_sticky,
  output logic                  err_any,
  output logic                  first_err_vld,
  output logic [CH_W-1:0]       first_err_ch,
  output logic [4:0]            first_err_code,
  output logic [N_CH*OCC_W-1:0] occ,
  output logic [N_CH*CNT_W-1:0] cov_full,
  output logic [N_CH*CNT_W-1:0] cov_empty
);

  logic [5*N_CH-1:0] det;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic             wa, ra, spurious, mismatch;
      logic [OCC_W-1:0] occ_reg;
      logic [CNT_W-1:0] cov_full_reg, cov_empty_reg;

      assign wa = wr_en[gi] & ~wr_full[gi];
      assign ra = rd_en[gi] & ~rd_empty[gi];

      // Flag consistency is judged against occupancy before this cycle's update.
      assign mismatch = ((occ_reg == OCC_W'(DEPTH)) != wr_full[gi]) ||
                        ((occ_reg == '0) != rd_empty[gi]);

      if (RD_LAT == 0) begin : g_lat0
        assign spurious = rd_valid[gi] & ~ra;
      end else begin : g_lat1
        logic ra_d_reg;
        always_ff @(posedge clk) begin
          if (rst) ra_d_reg <= 1'b0;
          else     ra_d_reg <= ra;
        end
        assign spurious = rd_valid[gi] & ~ra_d_reg;
      end

      assign det[5*gi +: 5] = {mismatch, spurious, rd_en[gi] & rd_empty[gi],
                               wr_en[gi] & wr_full[gi], wr_full[gi] & rd_empty[gi]} & ERR_MASK;

      always_ff @(posedge clk) begin
        if (rst) begin
          occ_reg       <= '0;
          cov_full_reg  <= '0;
          cov_empty_reg <= '0;
        end else begin
          if (wa && !ra && occ_reg != OCC_W'(DEPTH))
            occ_reg <= occ_reg + OCC_W'(1);
          else if (ra && !wa && occ_reg != '0)
            occ_reg <= occ_reg - OCC_W'(1);
          if (wr_full[gi] && cov_full_reg != '1)
            cov_full_reg <= cov_full_reg + CNT_W'(1);
          if (rd_empty[gi] && cov_empty_reg != '1)
            cov_empty_reg <= cov_empty_reg + CNT_W'(1);
        end
      end

      assign occ[gi*OCC_W +: OCC_W]       = occ_reg;
      assign cov_full[gi*CNT_W +: CNT_W]  = cov_full_reg;
      assign cov_empty[gi*CNT_W +: CNT_W] = cov_empty_reg;
    end
  endgenerate

  logic [5*N_CH-1:0] err_sticky_reg, err_sticky_next;
  logic              err_any_reg, first_err_vld_reg;
  logic [CH_W-1:0]   first_err_ch_reg, sel_ch;
  logic [4:0]        first_err_code_reg, sel_code;
  logic              err_new;

  // Descending scan so the lowest erroring channel is the one left selected.
  always_comb begin
    sel_ch   = '0;
    sel_code = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (|det[5*c +: 5]) begin
        sel_ch   = CH_W'(c);
        sel_code = det[5*c +: 5];
      end
    end
    err_new         = |det;
    err_sticky_next = (err_clr ? '0 : err_sticky_reg) | det;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_reg     <= '0;
      err_any_reg        <= 1'b0;
      first_err_vld_reg  <= 1'b0;
      first_err_ch_reg   <= '0;
      first_err_code_reg <= '0;
    end else begin
      err_sticky_reg <= err_sticky_next;
      err_any_reg    <= |err_sticky_next;
      // A fresh error in the clearing cycle re-arms the capture with that error.
      if (err_new && (err_clr || !first_err_vld_reg)) begin
        first_err_vld_reg  <= 1'b1;
        first_err_ch_reg   <= sel_ch;
        first_err_code_reg <= sel_code;
      end else if (err_clr) begin
        first_err_vld_reg  <= 1'b0;
        first_err_ch_reg   <= '0;
        first_err_code_reg <= '0;
      end
    end
  end

  assign err_sticky     = err_sticky_reg;
  assign err_any        = err_any_reg;
  assign first_err_vld  = first_err_vld_reg;
  assign first_err_ch   = first_err_ch_reg;
  assign first_err_code = first_err_code_reg;

endmodule

// File: tb/tb_fifo_protocol_monitor.sv
// Directed bench for fifo_protocol_monitor: a default-parameter instance plus a
// second instance with E4 masked and 2-bit coverage counters sharing the same stimulus.
module tb_fifo_protocol_monitor;
  localparam int N_CH = 4, DEPTH = 16, OCC_W = 5, CNT_W = 16;

  logic clk = 1'b0, rst = 1'b1, err_clr = 1'b0;
  logic [N_CH-1:0] wr_en = '0, wr_full = '0, rd_en = '0, rd_empty = '1, rd_valid = '0;

  logic [5*N_CH-1:0]     err_sticky, err_sticky2;
  logic                  err_any, err_any2, first_err_vld, first_err_vld2;
  logic [1:0]            first_err_ch, first_err_ch2;
  logic [4:0]            first_err_code, first_err_code2;
  logic [N_CH*OCC_W-1:0] occ, occ2;
  logic [N_CH*CNT_W-1:0] cov_full, cov_empty;
  logic [N_CH*2-1:0]     cov_full2, cov_empty2;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fifo_protocol_monitor #(.N_CH(N_CH), .DEPTH(DEPTH), .RD_LAT(1), .CNT_W(CNT_W),
                          .ERR_MASK(5'b11111)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_full(wr_full), .rd_en(rd_en),
    .rd_empty(rd_empty), .rd_valid(rd_valid), .err_clr(err_clr),
    .err_sticky(err_sticky), .err_any(err_any), .first_err_vld(first_err_vld),
    .first_err_ch(first_err_ch), .first_err_code(first_err_code), .occ(occ),
    .cov_full(cov_full), .cov_empty(cov_empty));

  fifo_protocol_monitor #(.N_CH(N_CH), .DEPTH(DEPTH), .RD_LAT(1), .CNT_W(2),
                          .ERR_MASK(5'b01111)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_full(wr_full), .rd_en(rd_en),
    .rd_empty(rd_empty), .rd_valid(rd_valid), .err_clr(err_clr),
    .err_sticky(err_sticky2), .err_any(err_any2), .first_err_vld(first_err_vld2),
    .first_err_ch(first_err_ch2), .first_err_code(first_err_code2), .occ(occ2),
    .cov_full(cov_full2), .cov_empty(cov_empty2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // n accepted writes into an empty channel, leaving flags consistent with occupancy n.
  task automatic fill(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en[ch] = 1'b1; wr_full[ch] = 1'b0; rd_empty[ch] = (i == 0);
      tick();
    end
    wr_en[ch] = 1'b0; wr_full[ch] = (n == DEPTH); rd_empty[ch] = (n == 0);
  endtask

  task automatic clear();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk("rst_sticky", 32'(err_sticky), 32'h0);
    chk("rst_any", 32'(err_any), 32'h0);
    chk("rst_first_vld", 32'(first_err_vld), 32'h0);
    chk("rst_occ", 32'(occ), 32'h0);
    chk("rst_cov_empty", 32'(cov_empty[CNT_W +: CNT_W]), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_any", 32'(err_any), 32'h0);
    chk("cov_empty_ch1", 32'(cov_empty[CNT_W +: CNT_W]), 32'd1);

    // Fill and drain channel 0
    fill(0, DEPTH);
    chk("fill_occ0", 32'(occ[0 +: OCC_W]), 32'd16);
    tick();
    chk("full_cov0", 32'(cov_full[0 +: CNT_W]), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      rd_en[0] = 1'b1; rd_empty[0] = 1'b0; wr_full[0] = (i == 0); rd_valid[0] = (i > 0);
      tick();
    end
    rd_en[0] = 1'b0; rd_valid[0] = 1'b1; rd_empty[0] = 1'b1; wr_full[0] = 1'b0;
    tick();
    rd_valid[0] = 1'b0;
    chk("drain_occ0", 32'(occ[0 +: OCC_W]), 32'd0);
    chk("drain_any", 32'(err_any), 32'h0);
    chk("drain_cov0", 32'(cov_full[0 +: CNT_W]), 32'd2);

    // Write on full, channel 2
    fill(2, DEPTH);
    wr_en[2] = 1'b1;
    tick();
    wr_en[2] = 1'b0;
    chk("wof_sticky", 32'(err_sticky), 32'h00800);
    chk("wof_vld", 32'(first_err_vld), 32'h1);
    chk("wof_ch", 32'(first_err_ch), 32'd2);
    chk("wof_code", 32'(first_err_code), 32'h02);
    chk("wof_occ2", 32'(occ[2*OCC_W +: OCC_W]), 32'd16);
    clear();
    chk("clr_sticky", 32'(err_sticky), 32'h0);
    chk("clr_vld", 32'(first_err_vld), 32'h0);

    // Simultaneous errors on channels 1 and 3
    rd_en[1] = 1'b1; wr_full[3] = 1'b1;
    tick();
    rd_en[1] = 1'b0; wr_full[3] = 1'b0;
    chk("sim_ch", 32'(first_err_ch), 32'd1);
    chk("sim_code", 32'(first_err_code), 32'h04);
    chk("sim_ch3_bits", 32'(err_sticky[15 +: 5]), 32'h11);
    clear();

    // Spurious valid, then a legitimate read/valid pair
    rd_valid[0] = 1'b1;
    tick();
    rd_valid[0] = 1'b0;
    chk("spur_ch0", 32'(err_sticky[0 +: 5]), 32'h08);
    clear();
    fill(0, 1);
    rd_en[0] = 1'b1;
    tick();
    rd_en[0] = 1'b0; rd_empty[0] = 1'b1; rd_valid[0] = 1'b1;
    tick();
    rd_valid[0] = 1'b0;
    chk("valid_ok_any", 32'(err_any), 32'h0);
    chk("valid_ok_occ0", 32'(occ[0 +: OCC_W]), 32'd0);

    // Flag mismatch at occupancy 3, full mask vs E4 masked
    fill(0, 3);
    rd_empty[0] = 1'b1; rd_en[0] = 1'b1;
    tick();
    rd_en[0] = 1'b0; rd_empty[0] = 1'b0;
    chk("mm_ch0", 32'(err_sticky[0 +: 5]), 32'h14);
    chk("mm_masked_ch0", 32'(err_sticky2[0 +: 5]), 32'h04);
    chk("mm_masked_code", 32'(first_err_code2), 32'h04);
    chk("mm_occ0", 32'(occ[0 +: OCC_W]), 32'd3);

    // Clear coincident with a new error: set wins
    err_clr = 1'b1; wr_en[2] = 1'b1;
    tick();
    err_clr = 1'b0; wr_en[2] = 1'b0;
    chk("clrnew_sticky", 32'(err_sticky), 32'h00800);
    chk("clrnew_vld", 32'(first_err_vld), 32'h1);
    chk("clrnew_ch", 32'(first_err_ch), 32'd2);
    chk("cov_sat_ch1", 32'(cov_empty2[2 +: 2]), 32'd3);

    // Reset mid-traffic
    rst = 1'b1; wr_en[0] = 1'b1;
    tick();
    chk("mrst_sticky", 32'(err_sticky), 32'h0);
    chk("mrst_any", 32'(err_any), 32'h0);
    chk("mrst_vld", 32'(first_err_vld), 32'h0);
    chk("mrst_code", 32'(first_err_code), 32'h0);
    chk("mrst_occ", 32'(occ), 32'h0);
    chk("mrst_cov_full2", 32'(cov_full[2*CNT_W +: CNT_W]), 32'h0);
    rst = 1'b0; wr_en = '0; rd_en = '0; wr_full = '0; rd_empty = '1;
    tick();
    chk("after_mrst_any", 32'(err_any), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
